ramcard_mem_bridge: RTL and testbench
=====================================

// Module: ramcard_mem_bridge
// PURPOSE
//  Sits directly downstream of the Saturn 128K language-card address decoder. Turns its
//  decoded card access (24-bit card RAM address, read/write enables) plus the CPU bus cycle
//  into a req/ack transaction on the shared SDRAM port.
//  - Holds the CPU via cpu_wait until the access completes.
//  - Returns read data to the CPU.
//  - Buffers one overlapping access and enforces a timeout.
// PARAMETERS
//  ADDR_W        24    width of ram_addr / mem_addr
//  TIMEOUT_CYC   255   max cycles waiting for mem_ack before abort (1..255)
// PORTS
//  clk           in   1       system clock; single clock domain
//  reset_n       in   1       synchronous reset, active low
//  cpu_strobe    in   1       1-cycle pulse: CPU bus cycle start; addr/data/rw valid this cycle
//  cpu_we        in   1       1 = CPU write cycle, 0 = read
//  cpu_dout      in   8       CPU write data
//  ram_addr      in   ADDR_W  card RAM address from the decoder
//  card_ram_we   in   1       card write-enabled for current address
//  card_ram_rd   in   1       card read-enabled for current address
//  cpu_din       out  8       read data returned to CPU (holds last value)
//  rd_valid      out  1       1-cycle pulse: cpu_din updated
//  cpu_wait      out  1       CPU stall request
//  mem_req       out  1       SDRAM request, level
//  mem_we        out  1       request is a write
//  mem_addr      out  ADDR_W  request address
//  mem_wdata     out  8       request write data
//  mem_ack       in   1       1-cycle completion pulse from SDRAM port
//  mem_rdata     in   8       read data, valid with mem_ack
//  timeout_err   out  1       sticky: a request timed out
//  ovf_err       out  1       sticky: an access was dropped (pending slot full)
// BEHAVIOUR
//  - Card access = cpu_strobe & ((cpu_we & card_ram_we) | (~cpu_we & card_ram_rd)).
//  - Strobes that are not card accesses are ignored: no request, no stall, no flag.
//  - All outputs registered. Reset (reset_n=0 at an edge) gives:
//    state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_din=8'h00, rd_valid=0,
//    cpu_wait=0, pending slot empty, timeout counter=0, timeout_err=0, ovf_err=0.
//  - Reset mid-transaction: mem_req drops at that edge. A late mem_ack is ignored.
//  - FSM states: IDLE, WAIT_ACK, GAP.
//  - IDLE, access sampled at edge T0:
//    - {mem_addr, mem_we=cpu_we, mem_wdata=cpu_dout} loaded; mem_req=1; cpu_wait=1.
//    - Counter cleared; next state WAIT_ACK.
//    - mem_addr/mem_we/mem_wdata stay stable while mem_req=1.
//  - WAIT_ACK, mem_ack sampled at edge Tk:
//    - mem_req=0.
//    - If read: cpu_din<=mem_rdata, rd_valid=1 for one cycle.
//    - If pending slot empty: cpu_wait=0, next state IDLE.
//    - Otherwise cpu_wait stays 1, next state GAP.
//    - Minimum latency: mem_req visible after T0; ack at T1 gives cpu_wait low after T1.
//  - WAIT_ACK, no ack: counter increments each cycle.
//    - When counter reaches TIMEOUT_CYC (counted from the cycle after T0):
//      - mem_req=0; timeout_err=1.
//      - If read: cpu_din<=8'hFF with rd_valid pulse.
//      - Exit exactly as for an ack.
//    - ack and timeout in the same cycle: ack wins, no error.
//  - GAP: one cycle with mem_req=0. Then the pending entry is issued exactly as from IDLE
//    and the slot is cleared. mem_req is never high on two adjacent transactions without
//    a low cycle between them.
//  - Access sampled while state != IDLE:
//    - Slot empty: captured {addr, we, wdata} into the slot; cpu_wait held 1.
//    - Slot full: access dropped, ovf_err=1.
//    - Access in the same cycle as mem_ack with slot empty: captured, then GAP.
//  - Sticky flags clear only on reset.
// TESTING
//  1. Read: strobe rd, card_ram_rd=1, ram_addr=24'h01D123; ack 3 cycles later, rdata=8'hA5
//     -> mem_req 3 cycles, mem_we=0, mem_addr=01D123, cpu_din=A5, 1 rd_valid pulse, wait drops.
//  2. Write: strobe wr, card_ram_we=1, cpu_dout=8'h3C, ram_addr=24'h02E000; ack after 1 cycle
//     -> mem_we=1, mem_wdata=3C, no rd_valid.
//  3. Gated write: strobe wr with card_ram_we=0 -> mem_req, cpu_wait never asserted.
//  4. Back-to-back: second access during WAIT_ACK -> 1 low GAP cycle, then second request
//     with its own addr. cpu_wait high continuously until second ack.
//     Third access while both busy -> ovf_err=1, only 2 requests issued.
//  5. Timeout: TIMEOUT_CYC=8, read, no ack -> mem_req drops after 8 cycles in WAIT_ACK,
//     cpu_din=FF, timeout_err=1.
//     Repeat with ack on the 8th cycle -> no error.
//  6. Reset mid-transaction: reset_n low during WAIT_ACK -> all outputs at reset values
//     next cycle. Subsequent stray mem_ack produces no rd_valid.

Source files
------------

// File: rtl/ramcard_mem_bridge.sv
// ramcard_mem_bridge
//   Bridges decoded Saturn 128K language-card accesses onto a shared SDRAM
//   req/ack port. Stalls the CPU (cpu_wait) while an access is in flight,
//   returns read data, buffers one overlapping access and aborts requests
//   that are not acknowledged within TIMEOUT_CYC cycles.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   cpu_strobe, cpu_we, cpu_dout CPU bus cycle start, direction, write data
//   ram_addr                     card RAM address from the decoder
//   card_ram_we, card_ram_rd     card write/read enables for ram_addr
//   cpu_din, rd_valid            read data to CPU, 1-cycle update pulse
//   cpu_wait                     CPU stall request
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    SDRAM request (level) and its attributes
//   mem_ack, mem_rdata           SDRAM completion pulse and read data
//   timeout_err, ovf_err         sticky error flags
module ramcard_mem_bridge #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_strobe,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_dout,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              card_ram_we,
    input  logic              card_ram_rd,
    output logic [7:0]        cpu_din,
    output logic              rd_valid,
    output logic              cpu_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              timeout_err,
    output logic              ovf_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        GAP
    } state_t;

    // Counter holds (cycles waited - 1); reaching TMO_LAST on a no-ack edge
    // means TIMEOUT_CYC edges have passed since the request went out.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t state, state_n;

    logic [7:0]        cnt, cnt_n;
    logic              pend_valid, pend_valid_n;
    logic [ADDR_W-1:0] pend_addr, pend_addr_n;
    logic              pend_we, pend_we_n;
    logic [7:0]        pend_wdata, pend_wdata_n;

    logic [7:0]        cpu_din_n;
    logic              rd_valid_n;
    logic              cpu_wait_n;
    logic              mem_req_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;
    logic              timeout_err_n;
    logic              ovf_err_n;

    logic access;
    logic tmo_hit;
    logic done;
    logic capture;
    logic drop;

    assign access  = cpu_strobe & ((cpu_we & card_ram_we) | (~cpu_we & card_ram_rd));
    assign tmo_hit = (cnt == TMO_LAST);
    assign done    = (state == WAIT_ACK) & (mem_ack | tmo_hit);
    // GAP is only entered with the slot full, so capture never fires there.
    assign capture = access & (state != IDLE) & ~pend_valid;
    assign drop    = access & (state != IDLE) & pend_valid;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            pend_we     <= 1'b0;
            pend_wdata  <= '0;
            cpu_din     <= 8'h00;
            rd_valid    <= 1'b0;
            cpu_wait    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pend_valid  <= pend_valid_n;
            pend_addr   <= pend_addr_n;
            pend_we     <= pend_we_n;
            pend_wdata  <= pend_wdata_n;
            cpu_din     <= cpu_din_n;
            rd_valid    <= rd_valid_n;
            cpu_wait    <= cpu_wait_n;
            mem_req     <= mem_req_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            timeout_err <= timeout_err_n;
            ovf_err     <= ovf_err_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (access) state_n = WAIT_ACK;
            WAIT_ACK: if (done) state_n = (pend_valid | capture) ? GAP : IDLE;
            GAP:      state_n = WAIT_ACK;
            default:  state_n = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_n         = cnt;
        pend_valid_n  = pend_valid;
        pend_addr_n   = pend_addr;
        pend_we_n     = pend_we;
        pend_wdata_n  = pend_wdata;
        cpu_din_n     = cpu_din;
        rd_valid_n    = 1'b0;
        cpu_wait_n    = cpu_wait;
        mem_req_n     = mem_req;
        mem_we_n      = mem_we;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        timeout_err_n = timeout_err;
        ovf_err_n     = ovf_err;

        case (state)
            IDLE: begin
                if (access) begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = cpu_we;
                    mem_addr_n  = ram_addr;
                    mem_wdata_n = cpu_dout;
                    cpu_wait_n  = 1'b1;
                    cnt_n       = '0;
                end
            end
            WAIT_ACK: begin
                if (done) begin
                    mem_req_n = 1'b0;
                    if (!mem_we) begin
                        cpu_din_n  = mem_ack ? mem_rdata : 8'hFF;
                        rd_valid_n = 1'b1;
                    end
                    if (!mem_ack) timeout_err_n = 1'b1;
                    cpu_wait_n = pend_valid | capture;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            GAP: begin
                mem_req_n    = 1'b1;
                mem_we_n     = pend_we;
                mem_addr_n   = pend_addr;
                mem_wdata_n  = pend_wdata;
                cpu_wait_n   = 1'b1;
                cnt_n        = '0;
                pend_valid_n = 1'b0;
            end
            default: ;
        endcase

        if (capture) begin
            pend_valid_n = 1'b1;
            pend_addr_n  = ram_addr;
            pend_we_n    = cpu_we;
            pend_wdata_n = cpu_dout;
        end
        if (drop) ovf_err_n = 1'b1;
    end

endmodule

// File: tb/tb_ramcard_mem_bridge.sv
// Testbench for ramcard_mem_bridge: directed scenarios with constant
// expectations, then a randomized run checked against a transaction-queue
// reference model.
module tb_ramcard_mem_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_strobe, cpu_we, card_ram_we, card_ram_rd;
    logic [7:0]  cpu_dout;
    logic [23:0] ram_addr;
    logic [7:0]  cpu_din;
    logic        rd_valid, cpu_wait, mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        timeout_err, ovf_err;

    int n_checks = 0;
    int n_fail   = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;

    ramcard_mem_bridge #(.ADDR_W(24), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_strobe(cpu_strobe), .cpu_we(cpu_we),
        .cpu_dout(cpu_dout), .ram_addr(ram_addr), .card_ram_we(card_ram_we),
        .card_ram_rd(card_ram_rd), .cpu_din(cpu_din), .rd_valid(rd_valid),
        .cpu_wait(cpu_wait), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req && !req_prev) req_rises++;
        req_prev = mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_strobe = 0; cpu_we = 0; cpu_dout = 0; ram_addr = 0;
        card_ram_we = 0; card_ram_rd = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    task automatic strobe(input logic we, input logic [23:0] a, input logic [7:0] d);
        cpu_strobe = 1; cpu_we = we; ram_addr = a; cpu_dout = d;
        card_ram_we = 1; card_ram_rd = 1;
    endtask

    task automatic test_reset();
        strobe(1'b0, 24'hABCDEF, 8'h12);
        reset_n = 0;
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_din, rd_valid, cpu_wait,
             timeout_err, ovf_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: req=%b we=%b addr=%h wd=%h din=%h rv=%b wait=%b te=%b oe=%b, required all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, cpu_din, rd_valid, cpu_wait, timeout_err, ovf_err);
        end
        clear_inputs();
        tick();
        reset_n = 1;
    endtask

    task automatic test_read();
        strobe(1'b0, 24'h01D123, 8'h00);
        card_ram_we = 0;
        tick();                      // T0
        clear_inputs();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, cpu_wait} !== {1'b1, 1'b0, 24'h01D123, 1'b1}) begin
            n_fail++;
            $display("FAIL read_issue: req=%b we=%b addr=%h wait=%b, required 1 0 01d123 1",
                     mem_req, mem_we, mem_addr, cpu_wait);
        end
        tick(); tick();              // T1, T2: still waiting
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL read_req_held: mem_req=%b, required 1", mem_req);
        end
        mem_ack = 1; mem_rdata = 8'hA5;
        tick();                      // T3
        clear_inputs();
        n_checks++;
        if ({mem_req, rd_valid, cpu_din, cpu_wait} !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL read_done: req=%b rv=%b din=%h wait=%b, required 0 1 a5 0",
                     mem_req, rd_valid, cpu_din, cpu_wait);
        end
        tick();
        n_checks++;
        if ({rd_valid, cpu_din} !== {1'b0, 8'hA5}) begin
            n_fail++; $display("FAIL read_pulse: rv=%b din=%h, required 0 a5", rd_valid, cpu_din);
        end
    endtask

    task automatic test_write();
        strobe(1'b1, 24'h02E000, 8'h3C);
        card_ram_rd = 0;
        tick();
        clear_inputs();
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_wait} !== {1'b1, 1'b1, 24'h02E000, 8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL write_issue: req=%b we=%b addr=%h wd=%h wait=%b, required 1 1 02e000 3c 1",
                     mem_req, mem_we, mem_addr, mem_wdata, cpu_wait);
        end
        mem_ack = 1; mem_rdata = 8'h99;
        tick();
        clear_inputs();
        n_checks++;
        if ({mem_req, rd_valid, cpu_wait, cpu_din} !== {1'b0, 1'b0, 1'b0, 8'hA5}) begin
            n_fail++;
            $display("FAIL write_done: req=%b rv=%b wait=%b din=%h, required 0 0 0 a5",
                     mem_req, rd_valid, cpu_wait, cpu_din);
        end
    endtask

    task automatic test_gated();
        for (int i = 0; i < 3; i++) begin
            strobe(i[0], 24'h000100 + 24'(i), 8'h55);
            if (i == 0) card_ram_rd = 0;      // read, not read-enabled
            if (i == 1) card_ram_we = 0;      // write, not write-enabled
            if (i == 2) cpu_strobe = 0;       // enables set but no strobe
            tick();
            clear_inputs();
            tick();
            n_checks++;
            if ({mem_req, cpu_wait, ovf_err, timeout_err} !== 4'b0000) begin
                n_fail++;
                $display("FAIL gated_%0d: req=%b wait=%b oe=%b te=%b, required 0 0 0 0",
                         i, mem_req, cpu_wait, ovf_err, timeout_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rises0;
        rises0 = req_rises;
        strobe(1'b0, 24'h111111, 8'h00);
        tick();                               // first issued
        strobe(1'b1, 24'h222222, 8'hC3);
        tick();                               // captured into slot
        strobe(1'b0, 24'h333333, 8'h00);
        tick();                               // dropped
        clear_inputs();
        n_checks++;
        if ({ovf_err, cpu_wait, mem_addr} !== {1'b1, 1'b1, 24'h111111}) begin
            n_fail++;
            $display("FAIL b2b_overflow: oe=%b wait=%b addr=%h, required 1 1 111111",
                     ovf_err, cpu_wait, mem_addr);
        end
        mem_ack = 1; mem_rdata = 8'h5A;
        tick();                               // first completes, enter gap
        clear_inputs();
        n_checks++;
        if ({mem_req, cpu_wait, rd_valid, cpu_din} !== {1'b0, 1'b1, 1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL b2b_gap: req=%b wait=%b rv=%b din=%h, required 0 1 1 5a",
                     mem_req, cpu_wait, rd_valid, cpu_din);
        end
        tick();                               // second issued
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_wait} !== {1'b1, 1'b1, 24'h222222, 8'hC3, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second: req=%b we=%b addr=%h wd=%h wait=%b, required 1 1 222222 c3 1",
                     mem_req, mem_we, mem_addr, mem_wdata, cpu_wait);
        end
        mem_ack = 1;
        tick();
        clear_inputs();
        tick(); tick(); tick();
        n_checks++;
        if ({mem_req, cpu_wait, ovf_err} !== 3'b001 || req_rises - rises0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_end: req=%b wait=%b oe=%b requests=%0d, required 0 0 1 requests=2",
                     mem_req, cpu_wait, ovf_err, req_rises - rises0);
        end
    endtask

    task automatic test_timeout(input bit ack_last);
        do_reset();
        strobe(1'b0, 24'h0ABCDE, 8'h00);
        tick();
        clear_inputs();
        for (int k = 1; k <= TMO; k++) begin
            if (k == TMO && ack_last) begin mem_ack = 1; mem_rdata = 8'h77; end
            tick();
            clear_inputs();
            if (k == TMO - 1) begin
                n_checks++;
                if (mem_req !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_early: mem_req=%b at cycle %0d, required 1", mem_req, k);
                end
            end
        end
        n_checks++;
        if ({mem_req, cpu_wait, rd_valid, timeout_err, cpu_din} !==
            {1'b0, 1'b0, 1'b1, !ack_last, ack_last ? 8'h77 : 8'hFF}) begin
            n_fail++;
            $display("FAIL timeout_%0d: req=%b wait=%b rv=%b te=%b din=%h, required 0 0 1 %0d %h",
                     ack_last, mem_req, cpu_wait, rd_valid, timeout_err, cpu_din,
                     !ack_last, ack_last ? 8'h77 : 8'hFF);
        end
    endtask

    task automatic test_reset_mid();
        strobe(1'b0, 24'h044444, 8'h00);
        tick();
        clear_inputs();
        tick();
        reset_n = 0;
        tick();
        reset_n = 1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_din, rd_valid, cpu_wait,
             timeout_err, ovf_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b addr=%h din=%h wait=%b te=%b oe=%b, required all 0",
                     mem_req, mem_addr, cpu_din, cpu_wait, timeout_err, ovf_err);
        end
        mem_ack = 1; mem_rdata = 8'hEE;
        tick();
        clear_inputs();
        n_checks++;
        if ({rd_valid, cpu_din, mem_req} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL stray_ack: rv=%b din=%h req=%b, required 0 00 0", rd_valid, cpu_din, mem_req);
        end
    endtask

    // Reference model: accepted accesses wait in a queue (head = active one).
    // A head is issued immediately if the bridge was empty, otherwise on the
    // edge after the previous completion; at most two accesses are held, and
    // nothing new is accepted while a queued head is waiting to go out.
    typedef struct { logic [23:0] a; logic w; logic [7:0] d; } acc_t;
    acc_t q[$];
    int   head_issue, comp_at, now;
    logic        m_req, m_we, m_rv, m_wait, m_terr, m_oerr;
    logic [23:0] m_addr;
    logic [7:0]  m_wdata, m_din;

    task automatic model_edge();
        bit acc, full, was_empty;
        acc_t x;
        acc       = cpu_strobe && (cpu_we ? card_ram_we : card_ram_rd);
        full      = (q.size() == 2) || (q.size() == 1 && head_issue < 0);
        was_empty = (q.size() == 0);
        m_rv = 0;
        if (q.size() > 0 && head_issue < 0 && comp_at == now - 1) begin
            head_issue = now;
            m_addr = q[0].a; m_we = q[0].w; m_wdata = q[0].d;
        end else if (q.size() > 0 && head_issue >= 0) begin
            if (mem_ack || (now - head_issue) >= TMO) begin
                if (!q[0].w) begin m_din = mem_ack ? mem_rdata : 8'hFF; m_rv = 1; end
                if (!mem_ack) m_terr = 1;
                void'(q.pop_front());
                head_issue = -1;
                comp_at = now;
            end
        end
        if (acc) begin
            if (full) m_oerr = 1;
            else begin
                x.a = ram_addr; x.w = cpu_we; x.d = cpu_dout;
                q.push_back(x);
                if (was_empty) begin
                    head_issue = now;
                    m_addr = x.a; m_we = x.w; m_wdata = x.d;
                end
            end
        end
        m_req  = (q.size() > 0) && (head_issue >= 0);
        m_wait = (q.size() > 0);
        now++;
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        do_reset();
        q.delete();
        head_issue = -1; comp_at = -10; now = 0;
        m_req = 0; m_we = 0; m_rv = 0; m_wait = 0; m_terr = 0; m_oerr = 0;
        m_addr = '0; m_wdata = '0; m_din = '0;
        for (int c = 0; c < 3000; c++) begin
            cpu_strobe  = ($urandom_range(0, 2) == 0);
            cpu_we      = $urandom_range(0, 1);
            card_ram_we = ($urandom_range(0, 3) != 0);
            card_ram_rd = ($urandom_range(0, 3) != 0);
            ram_addr    = 24'($urandom);
            cpu_dout    = 8'($urandom);
            mem_ack     = ($urandom_range(0, 4) == 0);
            mem_rdata   = 8'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            n_checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, cpu_din, rd_valid, cpu_wait, timeout_err, ovf_err} !==
                {m_req, m_we, m_addr, m_wdata, m_din, m_rv, m_wait, m_terr, m_oerr}) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_c%0d: req=%b we=%b addr=%h wd=%h din=%h rv=%b wait=%b te=%b oe=%b, required %b %b %h %h %h %b %b %b %b",
                             c, mem_req, mem_we, mem_addr, mem_wdata, cpu_din, rd_valid, cpu_wait, timeout_err, ovf_err,
                             m_req, m_we, m_addr, m_wdata, m_din, m_rv, m_wait, m_terr, m_oerr);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        tick();
        test_reset();
        test_read();
        test_write();
        test_gated();
        test_back_to_back();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
